timer_sequencer: RTL and testbench

- Avalon-MM master that programs and services the 16-bit-register interval timer peripheral: stop, load period, clear status, start; then acknowledges every timeout IRQ.
- Sits between a simple host-side command interface and the timer's s1 slave, so software and other logic never touch the timer registers directly.
- Emits one tick pulse and increments a tick counter per serviced timeout.

---
 rtl/timer_sequencer_pkg.sv | 43 ++++
 rtl/timer_sequencer_if.sv | 12 +
 rtl/timer_sequencer.sv | 131 +++++++++++++
 tb/tb_timer_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sequencer_pkg.sv
// Register map, control bits and state encoding shared by the interval-timer sequencer.
// TIMER_SEQ_SNAPSHOT_EN adds the counter-snapshot states.
package timer_seq_pkg;

    localparam logic [2:0] STATUS   = 3'd0;
    localparam logic [2:0] CONTROL  = 3'd1;
    localparam logic [2:0] PERIOD_L = 3'd2;
    localparam logic [2:0] PERIOD_H = 3'd3;
    localparam logic [2:0] SNAP_L   = 3'd4;
    localparam logic [2:0] SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE, WR_STOP, WR_PER_L, WR_PER_H, WR_CLR, WR_CTRL,
        RUN, ACK, STOP_WR, STOP_CLR
`ifdef TIMER_SEQ_SNAPSHOT_EN
        , SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP
`endif
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_req_t;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w             = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// Avalon-MM link between the sequencer (master) and the interval timer's s1 slave.
interface timer_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/timer_sequencer.sv
// Programs the interval timer (stop, period, clear, start) and services each timeout IRQ.
// Optional TIMER_SEQ_SNAPSHOT_EN adds a snap_req-triggered 32-bit counter snapshot.
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    timer_sequencer_if.master tmr,
`ifdef TIMER_SEQ_SNAPSHOT_EN
    input  logic              snap_req,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
`endif
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              done
);

    state_t      state, state_nxt;
    logic [31:0] period_q;
    logic        cont_q;
    bus_req_t    req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cfg_start) state_nxt = WR_STOP;
            WR_STOP:  state_nxt = WR_PER_L;
            WR_PER_L: state_nxt = WR_PER_H;
            WR_PER_H: state_nxt = WR_CLR;
            WR_CLR:   state_nxt = WR_CTRL;
            WR_CTRL:  state_nxt = RUN;
            RUN: begin
                // a stop wins over a coincident timeout, which is then left unserviced
                if (cfg_stop)     state_nxt = STOP_WR;
                else if (tmr.irq) state_nxt = ACK;
`ifdef TIMER_SEQ_SNAPSHOT_EN
                else if (snap_req) state_nxt = SNAP_WR;
`endif
            end
            ACK:      state_nxt = cont_q ? RUN : IDLE;
            STOP_WR:  state_nxt = STOP_CLR;
            STOP_CLR: state_nxt = IDLE;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR:   state_nxt = SNAP_RD_L;
            SNAP_RD_L: state_nxt = SNAP_RD_H;
            SNAP_RD_H: state_nxt = SNAP_CAP;
            SNAP_CAP:  state_nxt = RUN;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    // Bus strobes depend only on state and captured config, so reset drops them at once.
    always_comb begin
        req = '{cs: 1'b0, write_n: 1'b1, addr: STATUS, data: 16'h0000};
        case (state)
            WR_STOP, STOP_WR:
                req = '{cs: 1'b1, write_n: 1'b0, addr: CONTROL,
                        data: ctrl_word(1'b1, 1'b0, 1'b0, 1'b0)};
            WR_PER_L: req = '{cs: 1'b1, write_n: 1'b0, addr: PERIOD_L, data: period_q[15:0]};
            WR_PER_H: req = '{cs: 1'b1, write_n: 1'b0, addr: PERIOD_H, data: period_q[31:16]};
            WR_CLR, STOP_CLR, ACK:
                req = '{cs: 1'b1, write_n: 1'b0, addr: STATUS, data: 16'h0000};
            WR_CTRL:
                req = '{cs: 1'b1, write_n: 1'b0, addr: CONTROL,
                        data: ctrl_word(1'b0, 1'b1, cont_q, 1'b1)};
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR:   req = '{cs: 1'b1, write_n: 1'b0, addr: SNAP_L, data: 16'h0000};
            SNAP_RD_L: req = '{cs: 1'b1, write_n: 1'b1, addr: SNAP_L, data: 16'h0000};
            SNAP_RD_H: req = '{cs: 1'b1, write_n: 1'b1, addr: SNAP_H, data: 16'h0000};
`endif
            default: ;
        endcase
    end

    assign tmr.chipselect = req.cs;
    assign tmr.write_n    = req.write_n;
    assign tmr.address    = req.addr;
    assign tmr.writedata  = req.data;
    assign busy           = (state != IDLE);
    assign tick           = (state == ACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q   <= '0;
            cont_q     <= 1'b0;
            tick_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state != IDLE) && (state_nxt == IDLE);
            if (state == IDLE && cfg_start) begin
                period_q   <= cfg_period;
                cont_q     <= cfg_continuous;
                tick_count <= '0;
            end else if (state == ACK) begin
                tick_count <= tick_count + TICK_W'(1);
            end
        end
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    // readdata lags the address by one cycle: low half lands in SNAP_RD_H, high half in SNAP_CAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_value <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= (state == SNAP_CAP);
            if (state == SNAP_RD_H) snap_value[15:0]  <= tmr.readdata;
            if (state == SNAP_CAP)  snap_value[31:16] <= tmr.readdata;
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^tmr.readdata;
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer with a behavioural interval-timer slave attached.
module tb_timer_sequencer;
    import timer_seq_pkg::*;

    typedef struct { int cyc; logic rd; logic [2:0] a; logic [15:0] d; } op_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        busy, tick, done;
    logic [15:0] tick_count;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic        snap_req = 1'b0;
    logic [31:0] snap_value;
    logic        snap_valid;
`endif

    int  cyc = 0, n_chk = 0, n_fail = 0;
    op_t exp_q[$];
    int  exp_tick_q[$];
    int  exp_done_q[$];

    timer_sequencer_if tmr();

    timer_sequencer #(.TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .tmr(tmr),
`ifdef TIMER_SEQ_SNAPSHOT_EN
        .snap_req(snap_req), .snap_value(snap_value), .snap_valid(snap_valid),
`endif
        .busy(busy), .tick(tick), .tick_count(tick_count), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer model: counts period..0, sets TO on the edge after reaching 0.
    logic [31:0] m_period, m_cnt, m_snap;
    logic        m_run, m_cont, m_ito, m_to;
    logic [15:0] m_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_period <= '0; m_cnt <= '0; m_snap <= '0;
            m_run <= 1'b0; m_cont <= 1'b0; m_ito <= 1'b0; m_to <= 1'b0; m_rd <= '0;
        end else begin
            case (tmr.address)
                3'd0:    m_rd <= {14'd0, m_run, m_to};
                3'd4:    m_rd <= m_snap[15:0];
                3'd5:    m_rd <= m_snap[31:16];
                default: m_rd <= 16'h0000;
            endcase
            if (tmr.chipselect && !tmr.write_n) begin
                case (tmr.address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= tmr.writedata[0];
                        m_cont <= tmr.writedata[1];
                        if (tmr.writedata[2]) begin m_run <= 1'b1; m_cnt <= m_period; end
                        if (tmr.writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: m_period[15:0]  <= tmr.writedata;
                    3'd3: m_period[31:16] <= tmr.writedata;
                    3'd4, 3'd5: m_snap <= m_cnt;
                    default: ;
                endcase
            end
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_to  <= 1'b1;
                    m_cnt <= m_period;
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign tmr.irq      = m_to & m_ito;
    assign tmr.readdata = m_rd;

    // Scoreboard: each bus op / tick / done the DUT produces pops one expected entry.
    always @(negedge clk) begin : monitor
        op_t e;
        int  t;
        if (reset_n) begin
            if (tmr.chipselect) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_op: unexpected rd=%b addr=%0d data=%h at cyc %0d, required none",
                             tmr.write_n, tmr.address, tmr.writedata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.rd !== tmr.write_n || e.a !== tmr.address ||
                        (!e.rd && e.d !== tmr.writedata)) begin
                        n_fail++;
                        $display("FAIL bus_op: got cyc=%0d rd=%b addr=%0d data=%h, required cyc=%0d rd=%b addr=%0d data=%h",
                                 cyc, tmr.write_n, tmr.address, tmr.writedata, e.cyc, e.rd, e.a, e.d);
                    end
                end
            end
            if (tick) begin
                n_chk++;
                t = (exp_tick_q.size() == 0) ? -1 : exp_tick_q.pop_front();
                if (t != cyc) begin
                    n_fail++;
                    $display("FAIL tick: pulse at cyc %0d, required cyc %0d", cyc, t);
                end
            end
            if (done) begin
                n_chk++;
                t = (exp_done_q.size() == 0) ? -1 : exp_done_q.pop_front();
                if (t != cyc) begin
                    n_fail++;
                    $display("FAIL done: pulse at cyc %0d, required cyc %0d", cyc, t);
                end
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic start(input logic [31:0] p, input logic c, output int k);
        @(posedge clk); #1;
        k = cyc;
        cfg_period = p; cfg_continuous = c; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic push_prog(input int k, input logic [31:0] p, input logic c, input int n);
        op_t prog[5];
        prog[0] = '{k + 1, 1'b0, 3'd1, 16'h0008};
        prog[1] = '{k + 2, 1'b0, 3'd2, p[15:0]};
        prog[2] = '{k + 3, 1'b0, 3'd3, p[31:16]};
        prog[3] = '{k + 4, 1'b0, 3'd0, 16'h0000};
        prog[4] = '{k + 5, 1'b0, 3'd1, c ? 16'h0007 : 16'h0005};
        for (int i = 0; i < n; i++) exp_q.push_back(prog[i]);
    endtask

    task automatic push_op(input int c, input logic rd, input logic [2:0] a, input logic [15:0] d);
        op_t o;
        o = '{c, rd, a, d};
        exp_q.push_back(o);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_chk += 8;
        if (tmr.chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b, required 0", tmr.chipselect); end
        if (tmr.write_n !== 1'b1)    begin n_fail++; $display("FAIL rst_write_n: got %b, required 1", tmr.write_n); end
        if (tmr.address !== 3'd0)    begin n_fail++; $display("FAIL rst_addr: got %0d, required 0", tmr.address); end
        if (tmr.writedata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata: got %h, required 0000", tmr.writedata); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (tick !== 1'b0)           begin n_fail++; $display("FAIL rst_tick: got %b, required 0", tick); end
        if (tick_count !== 16'h0)    begin n_fail++; $display("FAIL rst_tick_count: got %0d, required 0", tick_count); end
        if (done !== 1'b0)           begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Period 9 continuous: program, three timeouts 10 cycles apart, then stop coinciding with irq.
    task automatic test_periodic;
        int k;
        start(32'd9, 1'b1, k);
        push_prog(k, 32'd9, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            exp_tick_q.push_back(k + 17 + 10 * i);
            push_op(k + 17 + 10 * i, 1'b0, 3'd0, 16'h0000);
        end
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL prog_busy: got %b, required 1", busy); end
        goto(k + 7);
        n_chk++;
        if (tick_count !== 16'd0) begin n_fail++; $display("FAIL prog_count: got %0d, required 0", tick_count); end
        goto(k + 40);
        n_chk++;
        if (tick_count !== 16'd3) begin n_fail++; $display("FAIL periodic_count: got %0d, required 3", tick_count); end
        goto(k + 46);
        cfg_stop = 1'b1;
        push_op(k + 47, 1'b0, 3'd1, 16'h0008);
        push_op(k + 48, 1'b0, 3'd0, 16'h0000);
        exp_done_q.push_back(k + 49);
        goto(k + 47);
        cfg_stop = 1'b0;
        goto(k + 52);
        n_chk += 3;
        if (tick_count !== 16'd3) begin n_fail++; $display("FAIL stop_irq_count: got %0d, required 3", tick_count); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_irq_busy: got %b, required 0", busy); end
        if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL periodic_pending: got %0d outstanding events, required 0",
                     exp_q.size() + exp_tick_q.size() + exp_done_q.size());
        end
        exp_q.delete(); exp_tick_q.delete(); exp_done_q.delete();
    endtask

    // One-shot period 4: single tick then done; stray start in RUN and stop in IDLE are ignored.
    task automatic test_oneshot;
        int k;
        start(32'd4, 1'b0, k);
        push_prog(k, 32'd4, 1'b0, 5);
        exp_tick_q.push_back(k + 12);
        push_op(k + 12, 1'b0, 3'd0, 16'h0000);
        exp_done_q.push_back(k + 13);
        goto(k + 2);
        n_chk++;
        if (tick_count !== 16'd0) begin n_fail++; $display("FAIL oneshot_clear: got %0d, required 0", tick_count); end
        goto(k + 8);
        cfg_start = 1'b1; cfg_period = 32'd7;
        goto(k + 9);
        cfg_start = 1'b0;
        goto(k + 13);
        n_chk += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL oneshot_done: got %b, required 1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL oneshot_busy: got %b, required 0", busy); end
        if (dut.state !== IDLE) begin n_fail++; $display("FAIL oneshot_state: got %0d, required IDLE", dut.state); end
        cfg_stop = 1'b1;
        goto(k + 14);
        cfg_stop = 1'b0;
        goto(k + 30);
        n_chk += 2;
        if (tick_count !== 16'd1) begin n_fail++; $display("FAIL oneshot_count: got %0d, required 1", tick_count); end
        if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL oneshot_pending: got %0d outstanding events, required 0",
                     exp_q.size() + exp_tick_q.size() + exp_done_q.size());
        end
        exp_q.delete(); exp_tick_q.delete(); exp_done_q.delete();
    endtask

    // Reset during WR_PER_H drops the bus at once; a later start replays the whole sequence.
    task automatic test_reset_mid;
        int k;
        start(32'h0001_0064, 1'b1, k);
        push_prog(k, 32'h0001_0064, 1'b1, 2);
        goto(k + 3);
        #2 reset_n = 1'b0;
        #1;
        n_chk += 5;
        if (tmr.chipselect !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cs: got %b, required 0", tmr.chipselect); end
        if (tmr.write_n !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_write_n: got %b, required 1", tmr.write_n); end
        if (tmr.address !== 3'd0 || tmr.writedata !== 16'h0) begin
            n_fail++; $display("FAIL mid_rst_bus: got addr=%0d data=%h, required 0/0000", tmr.address, tmr.writedata);
        end
        if (busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_status: got busy=%b tick=%b done=%b, required 0/0/0", busy, tick, done);
        end
        if (tick_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d, required 0", tick_count); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        start(32'd100, 1'b1, k);
        push_prog(k, 32'd100, 1'b1, 5);
        goto(k + 8);
        cfg_stop = 1'b1;
        push_op(k + 9, 1'b0, 3'd1, 16'h0008);
        push_op(k + 10, 1'b0, 3'd0, 16'h0000);
        exp_done_q.push_back(k + 11);
        goto(k + 9);
        cfg_stop = 1'b0;
        goto(k + 13);
        n_chk += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL replay_busy: got %b, required 0", busy); end
        if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL replay_pending: got %0d outstanding events, required 0",
                     exp_q.size() + exp_tick_q.size() + exp_done_q.size());
        end
        exp_q.delete(); exp_tick_q.delete(); exp_done_q.delete();
    endtask

`ifdef TIMER_SEQ_SNAPSHOT_EN
    // Counter holds P at cycle k+6; the snap write in cycle k+8 latches P-2.
    task automatic test_snapshot;
        int k;
        logic [31:0] p;
        p = 32'h0001_86A0;
        start(p, 1'b1, k);
        push_prog(k, p, 1'b1, 5);
        goto(k + 7);
        snap_req = 1'b1;
        push_op(k + 8, 1'b0, 3'd4, 16'h0000);
        push_op(k + 9, 1'b1, 3'd4, 16'h0000);
        push_op(k + 10, 1'b1, 3'd5, 16'h0000);
        goto(k + 8);
        snap_req = 1'b0;
        goto(k + 12);
        n_chk += 2;
        if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL snap_valid: got %b, required 1", snap_valid); end
        if (snap_value !== p - 32'd2) begin n_fail++; $display("FAIL snap_value: got %h, required %h", snap_value, p - 32'd2); end
        goto(k + 13);
        n_chk++;
        if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_pulse: got %b, required 0", snap_valid); end
        cfg_stop = 1'b1;
        push_op(k + 14, 1'b0, 3'd1, 16'h0008);
        push_op(k + 15, 1'b0, 3'd0, 16'h0000);
        exp_done_q.push_back(k + 16);
        goto(k + 14);
        cfg_stop = 1'b0;
        goto(k + 18);
        n_chk++;
        if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL snap_pending: got %0d outstanding events, required 0",
                     exp_q.size() + exp_tick_q.size() + exp_done_q.size());
        end
        exp_q.delete(); exp_tick_q.delete(); exp_done_q.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_periodic;
        test_oneshot;
        test_reset_mid;
`ifdef TIMER_SEQ_SNAPSHOT_EN
        test_snapshot;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
